// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to the attached device over the open-drain PS/2
// clock/data pair. The device-driven clock is synchronized and filtered
// before its falling edges advance the frame.
// Optional feature macro: PS2_TX_TIMEOUT_EN (frame watchdog; when undefined
// the block waits indefinitely and tx_error is tied low).
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_ack_ok,
  output logic       tx_error
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_SEND, S_WAIT_IDLE, S_DONE
  } state_t;

  state_t      state_q, state_n;
  logic        clk_s_p0, clk_s_p1, data_s_p0, data_s_p1;
  logic        clk_filt, fall_edge;
  logic [FW-1:0] flt_cnt;
  logic [9:0]  frame_q;
  logic        load;
  logic [3:0]  bit_cnt_q, bit_cnt_n;
  logic [IW-1:0] inh_cnt_q, inh_cnt_n;
  logic        clk_oe_q, clk_oe_n, data_oe_q, data_oe_n;
  logic        ack_q, ack_n, done_q, done_n, ready_q, ready_n, busy_q, busy_n;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] cyc_cnt_q, cyc_cnt_n;
  logic          err_q, err_n;
`endif

  // Two-flop synchronizers for the raw pad inputs (idle level is high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s_p0  <= 1'b1;
      clk_s_p1  <= 1'b1;
      data_s_p0 <= 1'b1;
      data_s_p1 <= 1'b1;
    end else begin
      clk_s_p0  <= ps2_clk_in;
      clk_s_p1  <= clk_s_p0;
      data_s_p0 <= ps2_data_in;
      data_s_p1 <= data_s_p0;
    end
  end

  // Stability filter: follow the synchronized clock only after FILTER_LEN equal samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_filt  <= 1'b1;
      flt_cnt   <= '0;
      fall_edge <= 1'b0;
    end else begin
      fall_edge <= 1'b0;
      if (clk_s_p1 == clk_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        clk_filt  <= clk_s_p1;
        flt_cnt   <= '0;
        fall_edge <= ~clk_s_p1;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  // Frame payload: data LSB first, odd parity, stop bit; no reset needed.
  always_ff @(posedge clk) begin
    if (load) frame_q <= {1'b1, ~^tx_data, tx_data};
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state_q;
    clk_oe_n  = clk_oe_q;
    data_oe_n = data_oe_q;
    bit_cnt_n = bit_cnt_q;
    inh_cnt_n = inh_cnt_q;
    ack_n     = ack_q;
    load      = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
    cyc_cnt_n = cyc_cnt_q;
    err_n     = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        if (tx_valid && ready_q) begin
          load      = 1'b1;
          clk_oe_n  = 1'b1;
          inh_cnt_n = '0;
          ack_n     = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
          err_n     = 1'b0;
`endif
          state_n   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          data_oe_n = 1'b1;
          state_n   = S_START;
        end else begin
          inh_cnt_n = inh_cnt_q + 1'b1;
        end
      end
      S_START: begin
        clk_oe_n  = 1'b0;
        bit_cnt_n = 4'd0;
`ifdef PS2_TX_TIMEOUT_EN
        cyc_cnt_n = '0;
`endif
        state_n   = S_SEND;
      end
      S_SEND: begin
        if (fall_edge) begin
          if (bit_cnt_q != 4'hF) bit_cnt_n = bit_cnt_q + 4'd1;
          if (bit_cnt_q < 4'd10) begin
            data_oe_n = ~frame_q[bit_cnt_q];
          end else if (bit_cnt_q == 4'd10) begin
            ack_n   = ~data_s_p1;
            state_n = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (clk_filt && data_s_p1) state_n = S_DONE;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    if (state_q == S_SEND || state_q == S_WAIT_IDLE) begin
      if (cyc_cnt_q == TO_LAST) begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        ack_n     = 1'b0;
        err_n     = 1'b1;
        state_n   = S_DONE;
      end else begin
        cyc_cnt_n = cyc_cnt_q + 1'b1;
      end
    end
`endif
    done_n  = (state_n == S_DONE);
    ready_n = (state_n == S_IDLE);
    busy_n  = (state_n != S_IDLE);
  end

  // State and registered outputs; reset releases both lines immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      bit_cnt_q <= 4'd0;
      inh_cnt_q <= '0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      clk_oe_q  <= clk_oe_n;
      data_oe_q <= data_oe_n;
      bit_cnt_q <= bit_cnt_n;
      inh_cnt_q <= inh_cnt_n;
      ack_q     <= ack_n;
      done_q    <= done_n;
      ready_q   <= ready_n;
      busy_q    <= busy_n;
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  // Frame watchdog counter and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      cyc_cnt_q <= cyc_cnt_n;
      err_q     <= err_n;
    end
  end
  assign tx_error = err_q;
`else
  assign tx_error = 1'b0;
`endif

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_ready    = ready_q;
  assign busy        = busy_q;
  assign tx_done     = done_q;
  assign tx_ack_ok   = ack_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model
// (40-cycle device clock period, open-drain line resolution).
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int FLT  = 2;
  localparam int TO   = 1000;
  localparam int HALF = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       dev_clk, dev_data;
  wire        ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       busy, tx_done, tx_ack_ok, tx_error;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .FILTER_LEN    (FLT),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_ack_ok  (tx_ack_ok),
    .tx_error   (tx_error)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // tx_done monitor, sampled on the falling edge
  int   done_cnt = 0;
  logic done_prev = 1'b0;
  logic d_ack, d_err, d_clk_oe, d_data_oe, ready_after, done_after;

  always @(negedge clk) begin
    if (done_prev) begin
      ready_after = tx_ready;
      done_after  = tx_done;
    end
    if (tx_done === 1'b1) begin
      done_cnt++;
      d_ack     = tx_ack_ok;
      d_err     = tx_error;
      d_clk_oe  = ps2_clk_oe;
      d_data_oe = ps2_data_oe;
    end
    done_prev = tx_done;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Request a byte and check the inhibit/start timing relative to the accept edge T.
  task automatic start_tx(input string tag, input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    chk({tag, "_T1_clk_oe"}, 32'(ps2_clk_oe), 32'd1);
    chk({tag, "_T1_ready"}, 32'(tx_ready), 32'd0);
    chk({tag, "_T1_busy"}, 32'(busy), 32'd1);
    repeat (19) @(posedge clk);
    #1;
    chk({tag, "_T20_data_oe"}, 32'(ps2_data_oe), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_T21_data_oe"}, 32'(ps2_data_oe), 32'd1);
    chk({tag, "_T21_clk_oe"}, 32'(ps2_clk_oe), 32'd1);
    @(posedge clk); #1;
    chk({tag, "_T22_clk_oe"}, 32'(ps2_clk_oe), 32'd0);
    chk({tag, "_T22_ready"}, 32'(tx_ready), 32'd0);
  endtask

  // Device: clocks up to stop_after falling edges, samples the line on each rise.
  task automatic run_dev(input bit ack, input int glitch_bit, input int stop_after,
                         output logic [10:0] bits);
    bits = '1;
    repeat (10) @(negedge clk);
    for (int i = 1; i <= stop_after; i++) begin
      if (i == 11 && ack) dev_data = 1'b0;
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      bits[i-1] = ps2_data_in;
      for (int k = 0; k < HALF; k++) begin
        @(negedge clk);
        dev_clk = (i == glitch_bit && k == 8) ? 1'b0 : 1'b1;
      end
    end
    dev_data = 1'b1;
  endtask

  // Wait (bounded) for one tx_done pulse and check the frame outcome.
  task automatic finish_chk(input string tag, input int base, input logic ack_exp);
    for (int c = 0; c < 2000 && done_cnt == base; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk({tag, "_done_pulses"}, 32'(done_cnt - base), 32'd1);
    chk({tag, "_ack_ok"}, 32'(d_ack), 32'(ack_exp));
    chk({tag, "_error"}, 32'(d_err), 32'd0);
    chk({tag, "_clk_oe_rel"}, 32'(d_clk_oe), 32'd0);
    chk({tag, "_data_oe_rel"}, 32'(d_data_oe), 32'd0);
    chk({tag, "_ready_next"}, 32'(ready_after), 32'd1);
    chk({tag, "_done_1cyc"}, 32'(done_after), 32'd0);
  endtask

  logic [10:0] seen;
  int          base;

  initial begin
    rst      = 1'b1;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_ack", 32'(tx_ack_ok), 32'd0);
    chk("rst_err", 32'(tx_error), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1/2: 0xED with acknowledge, inhibit/start timing
    base = done_cnt;
    start_tx("ed", 8'hED);
    run_dev(1'b1, 0, 11, seen);
    chk("ed_bits", 32'(seen), 32'h3ED);
    finish_chk("ed", base, 1'b1);

    // 3: 0x55 with a one-cycle clock glitch during bit 3
    base = done_cnt;
    start_tx("gl", 8'h55);
    run_dev(1'b1, 3, 11, seen);
    chk("gl_bits", 32'(seen), 32'h355);
    finish_chk("gl", base, 1'b1);

    // 4: 0xF4 without acknowledge (parity 0, ack line stays high)
    base = done_cnt;
    start_tx("na", 8'hF4);
    run_dev(1'b0, 0, 11, seen);
    chk("na_bits", 32'(seen), 32'h6F4);
    finish_chk("na", base, 1'b0);

    // 5: device never clocks
    base = done_cnt;
    start_tx("to", 8'hA5);
`ifdef PS2_TX_TIMEOUT_EN
    repeat (999) @(posedge clk);
    #1;
    chk("to_done_early", 32'(tx_done), 32'd0);
    chk("to_busy_early", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("to_done", 32'(tx_done), 32'd1);
    chk("to_error", 32'(tx_error), 32'd1);
    chk("to_ack", 32'(tx_ack_ok), 32'd0);
    chk("to_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("to_data_oe", 32'(ps2_data_oe), 32'd0);
    @(posedge clk); #1;
    chk("to_ready_next", 32'(tx_ready), 32'd1);
    chk("to_done_1cyc", 32'(tx_done), 32'd0);
`else
    repeat (2000) @(posedge clk);
    #1;
    chk("to_busy_hold", 32'(busy), 32'd1);
    chk("to_ready_hold", 32'(tx_ready), 32'd0);
    chk("to_no_done", 32'(done_cnt - base), 32'd0);
    chk("to_error_tied", 32'(tx_error), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("to_rst_ready", 32'(tx_ready), 32'd1);
`endif
    repeat (5) @(negedge clk);

    // 6: reset after 4 data bits of 0xA5 (bit 3 = 0 so data is driven low)
    base = done_cnt;
    start_tx("rs", 8'hA5);
    run_dev(1'b1, 0, 4, seen);
    chk("rs_bits_lo", 32'(seen[3:0]), 32'h5);
    @(negedge clk);
    chk("rs_pre_data_oe", 32'(ps2_data_oe), 32'd1);
    rst = 1'b1;
    #1;
    chk("rs_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("rs_data_oe", 32'(ps2_data_oe), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_ready", 32'(tx_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rs_no_done", 32'(done_cnt - base), 32'd0);

    base = done_cnt;
    start_tx("z", 8'h00);
    run_dev(1'b1, 0, 11, seen);
    chk("z_bits", 32'(seen), 32'h300);
    finish_chk("z", base, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
